// File: rtl/pwm_line_feeder.sv
// Buffers pixel words in a FIFO and, on each line tick with a full line buffered,
// emits a start pulse followed by STAGE words (one per clock) for the PWM data latch.
module pwm_line_feeder #(
  parameter int DWIDTH      = 8,
  parameter int STAGE       = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_PERIOD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear_flags,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              start,
  output logic [DWIDTH-1:0] data,
  output logic              line_done,
  output logic              underrun,
  output logic [7:0]        miss_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int CW = (LINE_PERIOD > 1) ? $clog2(LINE_PERIOD) : 1;
  localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;

  typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level;
  logic [CW-1:0]     cnt;
  logic              tick;
  logic              wr_en;
  logic              pop;
  logic              last_word;

  assign in_ready  = !rst && (level < LW'(FIFO_DEPTH));
  assign wr_en     = in_valid && in_ready;
  assign tick      = (cnt == CW'(LINE_PERIOD - 1));
  assign last_word = (idx == IW'(STAGE - 1));
  // The head is popped on the same edge that loads it into the data register.
  assign pop       = (state == START) || (state == SEND && !last_word);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      if (wr_en && !pop)      level <= level + LW'(1);
      else if (pop && !wr_en) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      start      <= 1'b0;
      data       <= '0;
      line_done  <= 1'b0;
      underrun   <= 1'b0;
      miss_count <= 8'd0;
    end else begin
      start     <= 1'b0;
      line_done <= 1'b0;
      data      <= '0;
      case (state)
        IDLE: begin
          if (tick && enable) begin
            if (level >= LW'(STAGE)) begin
              state <= START;
              start <= 1'b1;
            end else if (!clear_flags) begin
              underrun <= 1'b1;
              if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            end
          end
        end
        START: begin
          data  <= mem[rptr];
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (last_word) begin
            line_done <= 1'b1;
            state     <= DONE;
          end else begin
            data <= mem[rptr];
            idx  <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (clear_flags) begin
        underrun   <= 1'b0;
        miss_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_line_feeder.sv
// Scoreboard bench: accepted words are queued as expected line data; a negedge
// monitor checks start timing, word order, line_done and idle quiet outputs.
module tb_pwm_line_feeder;

  localparam int STAGE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear_flags = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       start;
  logic [7:0] data;
  logic       line_done;
  logic       underrun;
  logic [7:0] miss_count;

  pwm_line_feeder #(.DWIDTH(8), .STAGE(STAGE), .FIFO_DEPTH(16), .LINE_PERIOD(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_flags(clear_flags),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .data(data), .line_done(line_done),
    .underrun(underrun), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [7:0] exp_q[$];
  int lines_expected = 0;
  int exp_start = -1;
  int mphase = 0;
  int mk = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      mphase = 0;
      mk = 0;
    end else begin
      case (mphase)
        0: begin
          if (start) begin
            if (lines_expected == 0) chk("unexpected_start", 32'd1, 32'd0);
            else lines_expected--;
            if (exp_start >= 0) begin
              chk("start_cycle", cyc, exp_start);
              exp_start = -1;
            end
            chk("start_data_zero", {24'd0, data}, 32'd0);
            mphase = 1;
            mk = 0;
          end else begin
            chk("idle_quiet", {23'd0, line_done, data}, 32'd0);
          end
        end
        1: begin
          if (exp_q.size() == 0) chk("word_no_expected", {24'd0, data}, 32'hFFFF_FFFF);
          else chk("word", {24'd0, data}, {24'd0, exp_q.pop_front()});
          chk("start_low_in_send", {31'd0, start}, 32'd0);
          mk++;
          if (mk == STAGE) mphase = 2;
        end
        default: begin
          chk("line_done", {31'd0, line_done}, 32'd1);
          mphase = 0;
        end
      endcase
    end
  end

  task automatic wr(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("write_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
    end
    #1 in_valid = 1'b0;
  endtask

  // Returns at the negedge of the next tick cycle (period counter at 63).
  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while ((cyc % 64) != 63 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % 64) != 63) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_lines();
    int n = 0;
    @(negedge clk);
    while (!(lines_expected == 0 && mphase == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("lines_complete", lines_expected, 32'd0);
  endtask

  task automatic hold_writes(input int iters, inout logic [7:0] next_d, output int acc);
    acc = 0;
    for (int i = 0; i < iters; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = next_d;
      if (in_ready) begin
        exp_q.push_back(next_d);
        next_d = next_d + 8'd1;
        acc++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nd;
    int acc;

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outputs", {13'd0, start, line_done, underrun, miss_count, data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset-then-stream
    enable = 1'b1;
    lines_expected = 1;
    exp_start = 64;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    wait_lines();
    chk("stream_underrun", {31'd0, underrun}, 32'd0);

    // Underrun: 5 words at tick 127, then 3 more for tick 191
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    wait_tick();
    chk("underrun_tick_cycle", cyc, 32'd127);
    @(negedge clk);
    chk("underrun_flag", {31'd0, underrun}, 32'd1);
    chk("underrun_miss1", {24'd0, miss_count}, 32'd1);
    lines_expected = 1;
    exp_start = 192;
    for (int i = 5; i < 8; i++) wr(8'h10 + 8'(i));
    wait_lines();

    // Full FIFO with enable low
    enable = 1'b0;
    nd = 8'h30;
    hold_writes(24, nd, acc);
    chk("full_accept_count", acc, 32'd16);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    wait_tick();
    @(negedge clk);
    enable = 1'b1;
    lines_expected = 1;
    exp_start = 320;
    wait_tick();
    @(negedge clk);
    chk("ready_low_at_start", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
    hold_writes(8, nd, acc);
    wait_lines();

    // Clear flags, then enable drop mid-line
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("clear_underrun", {31'd0, underrun}, 32'd0);
    chk("clear_miss", {24'd0, miss_count}, 32'd0);
    lines_expected = 1;
    exp_start = 384;
    wait_tick();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_lines();
    wait_tick();
    wait_tick();
    @(negedge clk);
    chk("disabled_underrun", {31'd0, underrun}, 32'd0);
    chk("disabled_miss", {24'd0, miss_count}, 32'd0);

    // Drain remaining words, then saturate the miss counter
    enable = 1'b1;
    lines_expected = 1;
    exp_start = 576;
    wait_lines();
    for (int i = 0; i < 300; i++) wait_tick();
    @(negedge clk);
    chk("sat_miss", {24'd0, miss_count}, 32'd255);
    chk("sat_underrun", {31'd0, underrun}, 32'd1);
    wait_tick();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("clear_prio_underrun", {31'd0, underrun}, 32'd0);
    chk("clear_prio_miss", {24'd0, miss_count}, 32'd0);
    wait_tick();
    @(negedge clk);
    chk("miss_after_clear", {24'd0, miss_count}, 32'd1);

    // Async reset at word index 3
    lines_expected = 1;
    for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i));
    wait_tick();
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_data", {24'd0, data}, 32'd0);
    chk("arst_start", {31'd0, start}, 32'd0);
    chk("arst_flags", {23'd0, line_done, miss_count}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    lines_expected = 0;
    exp_start = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lines_expected = 1;
    exp_start = 64;
    for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i));
    wait_lines();
    chk("post_reset_underrun", {31'd0, underrun}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
